// File: rtl/btn_pkg.sv
// Shared types and helpers for the button debounce slice.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    // Bits needed to count 0 .. debounce_cycles-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned debounce_cycles);
        return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchronizer, debounce FSM with stability counter,
// press pulse and optional release pulse (BTN_RELEASE_PULSE_EN).
module debounce_chan
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic btn_release
`endif
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= RELEASED;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            btn_release <= 1'b0;
`endif
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_press <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            btn_release <= 1'b0;
`endif
            unique case (state)
                RELEASED: begin
                    if (sync2) begin
                        state <= PRESS_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= RELEASED;
                        cnt       <= '0;
                        btn_level <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                        btn_release <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent debounce channels plus any_press reduction.
// Define BTN_RELEASE_PULSE_EN to add the btn_release pulse output.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             any_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic [N_BTN-1:0] btn_release
`endif
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_press(btn_press[i])
`ifdef BTN_RELEASE_PULSE_EN
            ,
            .btn_release(btn_release[i])
`endif
        );
    end

    always_comb begin
        any_press = |btn_press;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES=4, N_BTN=4.
module tb_btn_debounce;

    localparam int LAT = 6;  // 2 sync stages + 4 stable cycles

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic       any_press;
    logic [3:0] btn_release;

    btn_debounce #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .any_press(any_press)
`ifdef BTN_RELEASE_PULSE_EN
        ,
        .btn_release(btn_release)
`endif
    );

`ifndef BTN_RELEASE_PULSE_EN
    assign btn_release = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [3:0] p;
        logic [3:0] r;
    } ev_t;
    typedef struct {
        int       cyc;
        logic [3:0] lvl;
    } lv_t;

    ev_t evq[$];
    lv_t lvq[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic exp_press(input int at, input logic [3:0] m);
        ev_t e;
        e.cyc = at; e.p = m; e.r = '0;
        evq.push_back(e);
    endtask

    task automatic exp_rel(input int at, input logic [3:0] m);
`ifdef BTN_RELEASE_PULSE_EN
        ev_t e;
        e.cyc = at; e.p = '0; e.r = m;
        evq.push_back(e);
`endif
    endtask

    task automatic exp_lvl(input int at, input logic [3:0] l);
        lv_t v;
        v.cyc = at; v.lvl = l;
        lvq.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every cycle the pulse outputs must equal the scheduled event (or zero).
    always @(negedge clk) begin
        logic [3:0] ep;
        logic [3:0] er;
        ep = '0;
        er = '0;
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
            ep = evq[0].p;
            er = evq[0].r;
            void'(evq.pop_front());
        end
        chk("btn_press", btn_press, ep);
        chk("any_press", any_press, ep != 4'b0);
`ifdef BTN_RELEASE_PULSE_EN
        chk("btn_release", btn_release, er);
`endif
        while (lvq.size() > 0 && lvq[0].cyc == cyc) begin
            chk("btn_level", btn_level, lvq[0].lvl);
            void'(lvq.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset   = 1'b1;
        btn_raw = '0;
        tick(3);
        chk("reset_level", btn_level, 4'b0);
        chk("reset_press", btn_press, 4'b0);
        chk("reset_any", any_press, 1'b0);
        reset = 1'b0;
        tick(7);

        // Clean press and release on channel 0
        c = cyc;
        btn_raw[0] = 1'b1;
        exp_lvl(c + LAT - 1, 4'b0000);
        exp_lvl(c + LAT, 4'b0001);
        exp_press(c + LAT, 4'b0001);
        exp_lvl(c + LAT + 3, 4'b0001);
        tick(12);
        c = cyc;
        btn_raw[0] = 1'b0;
        exp_lvl(c + LAT - 1, 4'b0001);
        exp_lvl(c + LAT, 4'b0000);
        exp_rel(c + LAT, 4'b0001);
        tick(10);

        // Bounce on channel 1: 1,0,1,0 then held high
        c = cyc;
        btn_raw[1] = 1'b1; tick(1);
        btn_raw[1] = 1'b0; tick(1);
        btn_raw[1] = 1'b1; tick(1);
        btn_raw[1] = 1'b0; tick(1);
        btn_raw[1] = 1'b1;
        exp_lvl(c + 5, 4'b0000);
        exp_lvl(c + 4 + LAT - 1, 4'b0000);
        exp_lvl(c + 4 + LAT, 4'b0010);
        exp_press(c + 4 + LAT, 4'b0010);
        tick(14);
        c = cyc;
        btn_raw[1] = 1'b0;
        exp_lvl(c + LAT, 4'b0000);
        exp_rel(c + LAT, 4'b0010);
        tick(10);

        // Three-cycle glitch on channel 2 must be ignored
        c = cyc;
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        exp_lvl(c + LAT, 4'b0000);
        exp_lvl(c + LAT + 2, 4'b0000);
        tick(12);

        // Simultaneous press on channels 0 and 3
        c = cyc;
        btn_raw = 4'b1001;
        exp_lvl(c + LAT, 4'b1001);
        exp_press(c + LAT, 4'b1001);
        tick(10);
        c = cyc;
        btn_raw = 4'b0000;
        exp_lvl(c + LAT, 4'b0000);
        exp_rel(c + LAT, 4'b1001);
        tick(10);

        // Reset two cycles into a press; press restarts after reset
        c = cyc;
        btn_raw[0] = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midreset_level", btn_level, 4'b0);
        chk("midreset_press", btn_press, 4'b0);
        chk("midreset_any", any_press, 1'b0);
        reset = 1'b0;
        c = cyc;
        exp_lvl(c + LAT - 1, 4'b0000);
        exp_lvl(c + LAT, 4'b0001);
        exp_press(c + LAT, 4'b0001);
        tick(10);
        c = cyc;
        btn_raw[0] = 1'b0;
        exp_lvl(c + LAT, 4'b0000);
        exp_rel(c + LAT, 4'b0001);
        tick(10);

        chk("evq_drained", evq.size(), 0);
        chk("lvq_drained", lvq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
